// File: rtl/prbs_pkg.sv
// Shared PRBS-14 definitions used by the generator and the checker.
package prbs_pkg;

    localparam int          PRBS_N     = 14;
    localparam logic [13:0] PRBS_START = 14'h0001;

    typedef enum logic {SEARCH, LOCKED} prbs_chk_state_t;

    // x^14+x^5+x^3+x+1, Fibonacci, shift-left with feedback into bit 0
    function automatic logic [13:0] prbs_step(input logic [13:0] w);
        return {w[12:0], w[13] ^ w[4] ^ w[2] ^ w[0]};
    endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Received-word and status bundle between a PRBS source and prbs_checker.
interface prbs_checker_if
    import prbs_pkg::*;
#(
    parameter int N     = PRBS_N,
    parameter int ERR_W = 16
);
    logic [N-1:0]     din;
    logic             din_valid;
    logic             clr_cnt;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;

    modport master (
        output din, din_valid, clr_cnt,
        input  locked, err_pulse, err_count
    );

    modport slave (
        input  din, din_valid, clr_cnt,
        output locked, err_pulse, err_count
    );
endinterface

// File: rtl/prbs_checker_sat_counter.sv
// Saturating up-counter; clear wins over a same-cycle increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);
    localparam logic [W-1:0] ONE = W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && (q != '1))
            q <= q + ONE;
    end
endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS-14 checker: seeds from the stream, flywheels once locked,
// and counts mismatched words while locked.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int N          = PRBS_N,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int ERR_W      = 16
) (
    input logic           clk,
    input logic           rst,
    prbs_checker_if.slave bus
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLOCK_CNT + 1);

    if (N != PRBS_N) begin : g_bad_width
        $error("prbs_checker: taps are fixed for N=14");
    end

    prbs_chk_state_t state, state_n;
    logic [N-1:0]    exp_w, exp_n;
    logic [MW-1:0]   match_run, match_n;
    logic [UW-1:0]   miss_run, miss_n;
    logic            locked_q, locked_n;
    logic            pulse_q, pulse_n;
    logic            hit, err_inc;

    always_comb begin
        hit      = (bus.din == exp_w) && (bus.din != '0);
        state_n  = state;
        exp_n    = exp_w;
        match_n  = match_run;
        miss_n   = miss_run;
        locked_n = locked_q;
        pulse_n  = 1'b0;
        err_inc  = 1'b0;
        if (bus.din_valid) begin
            case (state)
                SEARCH: begin
                    exp_n = prbs_step(bus.din);
                    if (hit) begin
                        match_n = match_run + MW'(1);
                        if (int'(match_run) + 1 == LOCK_CNT) begin
                            state_n  = LOCKED;
                            locked_n = 1'b1;
                            miss_n   = '0;
                        end
                    end else begin
                        match_n = '0;
                    end
                end
                LOCKED: begin
                    exp_n = prbs_step(exp_w);
                    if (hit) begin
                        miss_n = '0;
                    end else begin
                        pulse_n = 1'b1;
                        err_inc = 1'b1;
                        miss_n  = miss_run + UW'(1);
                        // losing lock re-seeds from the word that tipped it over
                        if (int'(miss_run) + 1 == UNLOCK_CNT) begin
                            state_n  = SEARCH;
                            locked_n = 1'b0;
                            match_n  = '0;
                            exp_n    = prbs_step(bus.din);
                        end
                    end
                end
                default: state_n = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SEARCH;
            exp_w     <= '0;
            match_run <= '0;
            miss_run  <= '0;
            locked_q  <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state     <= state_n;
            exp_w     <= exp_n;
            match_run <= match_n;
            miss_run  <= miss_n;
            locked_q  <= locked_n;
            pulse_q   <= pulse_n;
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (err_inc),
        .clr (bus.clr_cnt),
        .q   (bus.err_count)
    );

    assign bus.locked    = locked_q;
    assign bus.err_pulse = pulse_q;
endmodule
